// File: rtl/control_types_pkg.sv
// Shared control encodings for the MEM stage: memory op codes, the load/store
// engine state type, and small op classification helpers.
// Pure declarations; no logic or state.
package control_types_pkg;

   typedef enum logic [3:0] {
      MEM_NOP,
      MEM_LB,
      MEM_LH,
      MEM_LW,
      MEM_LBU,
      MEM_LHU,
      MEM_SB,
      MEM_SH,
      MEM_SW
   } mem_op_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } mau_state_t;

   function automatic logic is_store(input mem_op_t op);
      return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
   endfunction

   function automatic logic is_load(input mem_op_t op);
      return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
             (op == MEM_LBU) || (op == MEM_LHU);
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Purpose: byte-lane steering for the load/store engine (store enables, store data replication, load extract/extend).
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows its inputs every cycle.
module mem_lane_align
   import control_types_pkg::*;
(
   input  mem_op_t     op,
   input  logic [1:0]  lane,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   // Pick the addressed byte and half-word out of the returned bus word.
   always_comb begin
      rbyte = rdata[7:0];
      case (lane)
         2'd1:    rbyte = rdata[15:8];
         2'd2:    rbyte = rdata[23:16];
         2'd3:    rbyte = rdata[31:24];
         default: rbyte = rdata[7:0];
      endcase
      rhalf = lane[1] ? rdata[31:16] : rdata[15:0];
   end

   // Byte enables and lane-replicated store data; loads always fetch the full word.
   always_comb begin
      be    = 4'b0000;
      wdata = 32'h0;
      case (op)
         MEM_SB: begin
            be    = 4'b0001 << lane;
            wdata = {4{store_data[7:0]}};
         end
         MEM_SH: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{store_data[15:0]}};
         end
         MEM_SW: begin
            be    = 4'b1111;
            wdata = store_data;
         end
         MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: be = 4'b1111;
         default: ;
      endcase
   end

   // Sign- or zero-extend the selected lane; stores and NOPs return zero.
   always_comb begin
      load_data = 32'h0;
      case (op)
         MEM_LB:  load_data = {{24{rbyte[7]}}, rbyte};
         MEM_LBU: load_data = {24'h0, rbyte};
         MEM_LH:  load_data = {{16{rhalf[15]}}, rhalf};
         MEM_LHU: load_data = {16'h0, rhalf};
         MEM_LW:  load_data = rdata;
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: MEM-stage load/store engine issuing one 32-bit bus access per op (optional MEM_MISALIGN_TRAP_EN traps misaligned ops).
// Latency: zero-wait access completes in the issue cycle; ready in request cycle k>=2 stalls k cycles, data at k+1.
// Backpressure: mem_stall held while the bus is waiting; bus_err pulse and zero data after TIMEOUT_CYCLES wait cycles.
module mem_access_unit
   import control_types_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_do_write_ctrl_mem,
   input  mem_op_t     mem_ctrl_mem,
   input  logic [31:0] alu_result_mem,
   input  logic [31:0] mem_data_in_mem,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata,
   output logic [31:0] load_data_mem,
   output logic        mem_stall,
   output logic        bus_err,
   output logic        misalign_fault
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
   localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   mau_state_t state_q, state_d;
   mem_op_t     op_q;
   logic [31:0] addr_q, data_q, cap_q, cap_d;
   logic [CNT_W-1:0] cnt_q;

   mem_op_t     cur_op;
   logic [31:0] cur_addr, cur_data, fmt_data;
   logic [1:0]  lane;
   logic        live_valid, trap_c;
   logic        req_c, stall_c, err_c, latch_en, cnt_inc, cap_en;
   logic [31:0] ld_c;

   // A store op must carry the write flag and a load op must not; any disagreement is a bubble.
   assign live_valid = (mem_ctrl_mem != MEM_NOP) &&
                       (is_store(mem_ctrl_mem) == mem_do_write_ctrl_mem);

`ifdef MEM_MISALIGN_TRAP_EN
   // Flag a live op whose address is not naturally aligned for its size.
   always_comb begin
      trap_c = 1'b0;
      case (mem_ctrl_mem)
         MEM_LH, MEM_LHU, MEM_SH: trap_c = live_valid && alu_result_mem[0];
         MEM_LW, MEM_SW:          trap_c = live_valid && (alu_result_mem[1:0] != 2'b00);
         default: ;
      endcase
   end
`else
   assign trap_c = 1'b0;
`endif

   // While waiting, the bus sees the latched request so it stays stable; otherwise the live op.
   assign cur_op   = (state_q == WAIT) ? op_q   : mem_ctrl_mem;
   assign cur_addr = (state_q == WAIT) ? addr_q : alu_result_mem;
   assign cur_data = (state_q == WAIT) ? data_q : mem_data_in_mem;

   // Force the lane to natural alignment; a trapped op never reaches the bus so this is harmless there.
   always_comb begin
      lane = cur_addr[1:0];
      case (cur_op)
         MEM_LH, MEM_LHU, MEM_SH: lane[0] = 1'b0;
         MEM_LW, MEM_SW:          lane    = 2'b00;
         default: ;
      endcase
   end

   mem_lane_align u_align (
      .op         (cur_op),
      .lane       (lane),
      .store_data (cur_data),
      .rdata      (bus_rdata),
      .be         (bus_be),
      .wdata      (bus_wdata),
      .load_data  (fmt_data)
   );

   // Next-state and per-cycle controls for issue, wait-state tracking and response.
   always_comb begin
      state_d  = state_q;
      req_c    = 1'b0;
      stall_c  = 1'b0;
      err_c    = 1'b0;
      ld_c     = 32'h0;
      latch_en = 1'b0;
      cnt_inc  = 1'b0;
      cap_en   = 1'b0;
      cap_d    = 32'h0;
      case (state_q)
         IDLE: begin
            if (live_valid && !trap_c) begin
               req_c = 1'b1;
               if (bus_ready) begin
                  ld_c = fmt_data;
               end else begin
                  stall_c  = 1'b1;
                  latch_en = 1'b1;
                  state_d  = WAIT;
               end
            end
         end
         WAIT: begin
            stall_c = 1'b1;
            if (TIMEOUT_EN && (cnt_q == CNT_MAX)) begin
               err_c   = 1'b1;
               cap_en  = 1'b1;
               state_d = RESP;
            end else begin
               req_c = 1'b1;
               if (bus_ready) begin
                  cap_en  = 1'b1;
                  cap_d   = fmt_data;
                  state_d = RESP;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         RESP: begin
            // EX/MEM still holds the op just completed, so nothing is issued here.
            ld_c    = cap_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset reaches the request and stall lines directly so they drop without a clock.
   assign bus_req        = req_c & ~rst;
   assign mem_stall      = stall_c & ~rst;
   assign bus_err        = err_c & ~rst;
   assign misalign_fault = trap_c & (state_q == IDLE) & ~rst;
   assign bus_we         = bus_req & is_store(cur_op);
   assign bus_addr       = {cur_addr[31:2], 2'b00};
   assign load_data_mem  = ld_c;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Hold the request for the duration of the wait states.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= MEM_NOP;
         addr_q <= 32'h0;
         data_q <= 32'h0;
      end else if (latch_en) begin
         op_q   <= mem_ctrl_mem;
         addr_q <= alu_result_mem;
         data_q <= mem_data_in_mem;
      end
   end

   // Count wait cycles of the current access for the timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          cnt_q <= '0;
      else if (latch_en) cnt_q <= '0;
      else if (cnt_inc)  cnt_q <= cnt_q + 1'b1;
   end

   // Capture the formatted load word (or zero on timeout) for the response cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         cap_q <= 32'h0;
      else if (cap_en) cap_q <= cap_d;
   end

endmodule
